// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: round-robin front end for one shared, fully pipelined
// signed multiplier. It grants at most one requester per cycle, sends that
// requester's operands into a shift-add multiplier pipeline, and carries an
// {valid, id} tag alongside so each product returns tagged with its requester.
module mult_rr_scheduler #(
   parameter  int OPP_W   = 4,
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ),
   localparam int LAT     = OPP_W + 1,
   localparam int CNT_W   = $clog2(LAT + 1)
) (
   input  logic                       clk,
   input  logic                       aresetn,
   input  logic                       en,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*OPP_W-1:0]   req_a,
   input  logic [NUM_REQ*OPP_W-1:0]   req_b,
   output logic                       rsp_valid,
   output logic [ID_W-1:0]            rsp_id,
   output logic [2*OPP_W-1:0]         rsp_data,
   output logic [CNT_W-1:0]           inflight,
   output logic                       busy
);

   localparam int PRD_W = 2 * OPP_W;

   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
   } tag_t;

   // Arbitration and control state
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  gnt_id;
   logic             gnt_found;
   logic             accept;
   tag_t             tag_q [LAT];
   tag_t             tag_d [LAT];
   logic [CNT_W-1:0] inflight_q, inflight_d;

   // Multiplier datapath: stage 0 latches operands, stage k adds partial
   // product k-1, so the last stage holds the finished product.
   logic [OPP_W-1:0] op_a, op_b;
   logic [PRD_W-1:0] pa_q  [LAT-1];
   logic [PRD_W-1:0] pa_d  [LAT-1];
   logic [OPP_W-1:0] pb_q  [LAT-1];
   logic [OPP_W-1:0] pb_d  [LAT-1];
   logic [PRD_W-1:0] acc_q [LAT];
   logic [PRD_W-1:0] acc_d [LAT];
   logic [PRD_W-1:0] pp;

   // Round-robin search: first valid requester at or after ptr, wrapping.
   always_comb begin : arb
      int               sum;
      logic [ID_W-1:0]  cand;
      // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
      gnt_found = 1'b0;
      gnt_id    = '0;
      sum       = 0;
      cand      = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         sum = int'(ptr_q) + off;
         if (sum >= NUM_REQ) sum = sum - NUM_REQ;
         cand = ID_W'(sum);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_id    = cand;
         end
      end
   end

   // Grant, pointer advance, operand mux, tag shift and in-flight count.
   always_comb begin
      accept    = gnt_found && en;
      req_ready = '0;
      if (accept) req_ready[gnt_id] = 1'b1;

      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
      end

      op_a = '0;
      op_b = '0;
      if (accept) begin
         op_a = req_a[gnt_id*OPP_W +: OPP_W];
         op_b = req_b[gnt_id*OPP_W +: OPP_W];
      end

      tag_d[0] = '0;
      if (accept) begin
         tag_d[0].vld = 1'b1;
         tag_d[0].id  = gnt_id;
      end
      for (int k = 1; k < LAT; k++) tag_d[k] = tag_q[k-1];

      inflight_d = inflight_q;
      case ({accept, tag_q[LAT-1].vld})
         2'b10:   inflight_d = inflight_q + CNT_W'(1);
         2'b01:   inflight_d = inflight_q - CNT_W'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   // Shift-add signed multiply: A is sign-extended, each lower bit of B adds
   // A shifted into place, and B's sign bit subtracts its weighted term.
   always_comb begin
      pp       = '0;
      pa_d[0]  = {{OPP_W{op_a[OPP_W-1]}}, op_a};
      pb_d[0]  = op_b;
      acc_d[0] = '0;
      for (int k = 1; k < LAT - 1; k++) begin
         pa_d[k] = pa_q[k-1];
         pb_d[k] = pb_q[k-1];
      end
      for (int k = 1; k < LAT; k++) begin
         pp = pb_q[k-1][k-1] ? (pa_q[k-1] << (k - 1)) : '0;
         if (k == LAT - 1) acc_d[k] = acc_q[k-1] - pp;
         else              acc_d[k] = acc_q[k-1] + pp;
      end
   end

   // Control state: pointer, tag pipeline and counter, cleared by reset.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         ptr_q      <= '0;
         inflight_q <= '0;
         for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
         ptr_q      <= ptr_d;
         inflight_q <= inflight_d;
         tag_q      <= tag_d;
      end
   end

   // Multiplier pipeline registers, advancing every cycle.
   always_ff @(posedge clk) begin
      // NOTE: datapath pipeline is not reset; the tag valid bits gate everything it produces.
      pa_q  <= pa_d;
      pb_q  <= pb_d;
      acc_q <= acc_d;
   end

   assign rsp_valid = tag_q[LAT-1].vld;
   assign rsp_id    = tag_q[LAT-1].id;
   assign rsp_data  = rsp_valid ? acc_q[LAT-1] : '0;
   assign inflight  = inflight_q;
   assign busy      = (inflight_q != '0);

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Self-checking bench for mult_rr_scheduler: a round-robin reference model
// predicts each grant, pushes the expected {due cycle, id, product} into a
// scoreboard queue, and the negedge monitor pops and compares responses.
module tb_mult_rr_scheduler;

   localparam int OPP_W   = 4;
   localparam int NUM_REQ = 4;
   localparam int LAT     = OPP_W + 1;
   localparam int DEPTH   = 256;

   logic                     clk;
   logic                     aresetn;
   logic                     en;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*OPP_W-1:0] req_a;
   logic [NUM_REQ*OPP_W-1:0] req_b;
   logic                     rsp_valid;
   logic [1:0]               rsp_id;
   logic [7:0]               rsp_data;
   logic [2:0]               inflight;
   logic                     busy;

   mult_rr_scheduler #(.OPP_W(OPP_W), .NUM_REQ(NUM_REQ)) dut (
      .clk       (clk),
      .aresetn   (aresetn),
      .en        (en),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .inflight  (inflight),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         due;
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   exp_t       sb_q [$];
   logic [1:0] log_id [$];
   logic [7:0] log_data [$];

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int max_inf = 0;

   logic [1:0]         mptr = '0;
   logic [NUM_REQ-1:0] acc_mask = '0;

   // Per-requester pending operand lists; head advances on each accept.
   logic [3:0] pend_a [NUM_REQ][DEPTH];
   logic [3:0] pend_b [NUM_REQ][DEPTH];
   int         head   [NUM_REQ];
   int         tail   [NUM_REQ];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] exp_prod(input logic [3:0] a, input logic [3:0] b);
      int          sa, sbv;
      logic [31:0] pv;
      sa  = a[3] ? int'(a) - 16 : int'(a);
      sbv = b[3] ? int'(b) - 16 : int'(b);
      pv  = 32'(sa * sbv);
      return pv[7:0];
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model and scoreboard, evaluated mid-cycle.
   always @(negedge clk) begin
      int         sz;
      logic       exp_v;
      logic       found;
      logic [1:0] g;
      logic [1:0] idx;
      logic [NUM_REQ-1:0] exp_rdy;
      exp_t       e;
      if (!aresetn) begin
         sb_q.delete();
         mptr     = '0;
         acc_mask = '0;
         check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         check("rst_rsp_id",    32'(rsp_id),    32'd0);
         check("rst_rsp_data",  32'(rsp_data),  32'd0);
         check("rst_inflight",  32'(inflight),  32'd0);
         check("rst_busy",      32'(busy),      32'd0);
      end else begin
         sz = sb_q.size();
         check("inflight", 32'(inflight), 32'(sz));
         check("busy",     32'(busy),     32'(sz != 0));
         if (int'(inflight) > max_inf) max_inf = int'(inflight);
         exp_v = (sz > 0) && (sb_q[0].due == cyc);
         check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
         if (rsp_valid) begin
            log_id.push_back(rsp_id);
            log_data.push_back(rsp_data);
         end
         if (exp_v) begin
            e = sb_q.pop_front();
            check("rsp_id",   32'(rsp_id),   32'(e.id));
            check("rsp_data", 32'(rsp_data), 32'(e.data));
         end
         found = 1'b0;
         g     = '0;
         for (int off = 0; off < NUM_REQ; off++) begin
            idx = mptr + 2'(off);
            if (!found && req_valid[idx]) begin
               found = 1'b1;
               g     = idx;
            end
         end
         exp_rdy = '0;
         if (found && en) exp_rdy[g] = 1'b1;
         check("req_ready", 32'(req_ready), 32'(exp_rdy));
         acc_mask = exp_rdy;
         if (found && en) begin
            e.due  = cyc + LAT;
            e.id   = g;
            e.data = exp_prod(req_a[g*OPP_W +: OPP_W], req_b[g*OPP_W +: OPP_W]);
            sb_q.push_back(e);
            mptr = g + 2'd1;
         end
      end
   end

   task automatic push_op(input int id, input int a, input int b);
      pend_a[id][tail[id]] = 4'(a);
      pend_b[id][tail[id]] = 4'(b);
      tail[id]++;
   endtask

   task automatic flush_ops();
      for (int i = 0; i < NUM_REQ; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
   endtask

   // One clock: retire accepted items, then present each requester's next item.
   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (acc_mask[i]) head[i]++;
         if (head[i] < tail[i]) begin
            req_valid[i]         = 1'b1;
            req_a[i*OPP_W +: 4]  = pend_a[i][head[i]];
            req_b[i*OPP_W +: 4]  = pend_b[i][head[i]];
         end else begin
            req_valid[i]         = 1'b0;
            req_a[i*OPP_W +: 4]  = '0;
            req_b[i*OPP_W +: 4]  = '0;
         end
      end
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      aresetn   = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      flush_ops();
      #1;
      check("rst_now_valid",    32'(rsp_valid), 32'd0);
      check("rst_now_data",     32'(rsp_data),  32'd0);
      check("rst_now_inflight", 32'(inflight),  32'd0);
      repeat (n) @(posedge clk);
      #1;
      aresetn = 1'b1;
   endtask

   logic [7:0] corner_exp [4];

   initial begin
      aresetn   = 1'b0;
      en        = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      flush_ops();
      corner_exp[0] = 8'h40;
      corner_exp[1] = 8'hC8;
      corner_exp[2] = 8'h00;
      corner_exp[3] = 8'h31;
      repeat (3) @(posedge clk);
      #1;
      aresetn = 1'b1;

      // Single op from requester 2: -3 * 5
      log_id.delete();
      log_data.delete();
      push_op(2, -3, 5);
      repeat (9) step();
      check("single_count", 32'(log_id.size()), 32'd1);
      if (log_id.size() == 1) begin
         check("single_id",   32'(log_id[0]),   32'd2);
         check("single_data", 32'(log_data[0]), 32'hF1);
      end

      // Fairness from ptr=0: all four requesters, two ops each
      do_reset(2);
      log_id.delete();
      log_data.delete();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NUM_REQ; i++) push_op(i, i + 1, r + 2);
      repeat (16) step();
      check("fair_count", 32'(log_id.size()), 32'd8);
      for (int k = 0; k < 8; k++)
         if (k < log_id.size()) check("fair_order", 32'(log_id[k]), 32'(k % 4));

      // Corner products through requester 0
      log_id.delete();
      log_data.delete();
      push_op(0, -8, -8);
      push_op(0, -8, 7);
      push_op(0, 0, -1);
      push_op(0, 7, 7);
      repeat (12) step();
      check("corner_count", 32'(log_data.size()), 32'd4);
      for (int k = 0; k < 4; k++)
         if (k < log_data.size()) check("corner_data", 32'(log_data[k]), 32'(corner_exp[k]));

      // en gating on requester 1
      log_id.delete();
      log_data.delete();
      en = 1'b0;
      push_op(1, 3, -2);
      for (int k = 0; k < 3; k++) begin
         step();
         #1;
         check("en_low_ready", 32'(req_ready), 32'd0);
      end
      step();
      en = 1'b1;
      #1;
      check("en_high_ready", 32'(req_ready), 32'b0010);
      repeat (8) step();
      check("en_count", 32'(log_id.size()), 32'd1);
      if (log_id.size() == 1) check("en_id", 32'(log_id[0]), 32'd1);

      // Reset with three operations in flight
      push_op(0, 1, 1);
      push_op(1, 2, 2);
      push_op(2, 3, 3);
      repeat (5) step();
      check("mid_inflight", 32'(inflight), 32'd3);
      log_id.delete();
      log_data.delete();
      do_reset(2);
      repeat (10) step();
      check("mid_no_rsp", 32'(log_id.size()), 32'd0);

      // Counter saturation and drain with one persistent requester
      max_inf = 0;
      for (int k = 0; k < 10; k++) push_op(3, k - 5, 3 - k);
      repeat (11) step();
      check("cnt_max", 32'(max_inf), 32'd5);
      repeat (6) step();
      check("cnt_drained", 32'(inflight), 32'd0);

      // Mixed random traffic with en toggling
      for (int c = 0; c < 60; c++) begin
         for (int i = 0; i < NUM_REQ; i++)
            if ((tail[i] - head[i] < 3) && ($urandom_range(0, 2) == 0))
               push_op(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
         step();
         en = ($urandom_range(0, 3) != 0);
      end
      en = 1'b1;
      repeat (20) step();
      check("final_sb_empty", 32'(sb_q.size()), 32'd0);
      check("final_inflight", 32'(inflight),    32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
